// File: rtl/bpu_update_sched.sv
// In-order scheduler from two branch-resolution slots to a single predictor table-update port.
// An update accepted at edge N is visible on wr_* from cycle N+1 when the queue was empty; there is no bypass.
// upd_ready deasserts when fewer than two entries are free. wr_* hold steady while the predictor stalls.
module bpu_update_sched #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd1_valid,
  input  logic [31:0]                upd1_pc,
  input  logic                       upd1_taken,
  input  logic [31:0]                upd1_target,
  input  logic [1:0]                 upd1_type,
  input  logic                       upd2_valid,
  input  logic [31:0]                upd2_pc,
  input  logic                       upd2_taken,
  input  logic [31:0]                upd2_target,
  input  logic [1:0]                 upd2_type,
  output logic                       upd_ready,
  input  logic                       hold,
  input  logic                       clear,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [31:0]                wr_pc,
  output logic                       wr_taken,
  output logic [31:0]                wr_target,
  output logic [1:0]                 wr_type,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           enq_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  typ;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic           deq;
  logic [CW-1:0]  space;
  logic           acc1;
  logic           acc2;
  logic           drop1;
  logic           drop2;
  logic [1:0]     n_acc;
  logic [1:0]     n_drop;
  logic [PW-1:0]  tail2;

  // Adds 0..2 to a statistics counter and pins it at all-ones on overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Handshake, free space (including the slot freed by this cycle's drain) and per-slot accept/drop.
  always_comb begin
    wr_valid  = (count != '0) && !hold && !clear;
    deq       = wr_valid && wr_ready;
    upd_ready = (count <= CW'(DEPTH - 2));
    space     = CW'(DEPTH) - count + CW'(deq);
    // Slot 1 is older, so it claims the first free entry; clear discards both without counting drops.
    acc1      = !clear && upd1_valid && (space != '0);
    acc2      = !clear && upd2_valid && (space > (acc1 ? CW'(1) : CW'(0)));
    drop1     = !clear && upd1_valid && !acc1;
    drop2     = !clear && upd2_valid && !acc2;
    n_acc     = {1'b0, acc1} + {1'b0, acc2};
    n_drop    = {1'b0, drop1} + {1'b0, drop2};
    tail2     = acc1 ? (tail + PW'(1)) : tail;
  end

  // Show-ahead view of the head entry.
  always_comb begin
    wr_pc     = mem[head].pc;
    wr_taken  = mem[head].taken;
    wr_target = mem[head].target;
    wr_type   = mem[head].typ;
  end

  // Storage writes; slot 2 lands behind slot 1 when both are accepted.
  always_ff @(posedge clk) begin
    if (acc1) mem[tail]  <= '{upd1_pc, upd1_taken, upd1_target, upd1_type};
    if (acc2) mem[tail2] <= '{upd2_pc, upd2_taken, upd2_target, upd2_type};
  end

  // Pointers, occupancy and statistics; clear empties the queue but leaves statistics alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PW'(deq);
        tail  <= tail + PW'(n_acc);
        count <= count + CW'(n_acc) - CW'(deq);
      end
      if (n_drop != 2'd0) overflow <= 1'b1;
      enq_cnt  <= sat_add(enq_cnt, n_acc);
      drop_cnt <= sat_add(drop_cnt, n_drop);
    end
  end

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed bench for bpu_update_sched: queue-based reference model checked every cycle,
// plus literal expectations at each scenario boundary.
// Inputs change 1ns after the rising edge; the model compares and advances on the falling edge.
module tb_bpu_update_sched;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              upd1_valid, upd1_taken, upd2_valid, upd2_taken;
  logic [31:0]       upd1_pc, upd1_target, upd2_pc, upd2_target;
  logic [1:0]        upd1_type, upd2_type;
  logic              upd_ready, hold, clear, wr_valid, wr_ready, wr_taken, overflow;
  logic [31:0]       wr_pc, wr_target;
  logic [1:0]        wr_type;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  enq_cnt, drop_cnt;

  bpu_update_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd1_target(upd1_target), .upd1_type(upd1_type),
    .upd2_valid(upd2_valid), .upd2_pc(upd2_pc), .upd2_taken(upd2_taken),
    .upd2_target(upd2_target), .upd2_type(upd2_type),
    .upd_ready(upd_ready), .hold(hold), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_pc(wr_pc), .wr_taken(wr_taken), .wr_target(wr_target), .wr_type(wr_type),
    .count(count), .overflow(overflow), .enq_cnt(enq_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: program-ordered queue of pending updates plus statistics.
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  typ;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_enq  = 0;
  int unsigned m_drop = 0;
  bit          m_ovf  = 1'b0;
  localparam int unsigned SAT = (1 << CNT_W) - 1;

  task automatic offer(input logic v, input ent_t e, inout int free);
    if (v) begin
      if (free > 0) begin
        mq.push_back(e);
        free--;
        m_enq = (m_enq < SAT) ? m_enq + 1 : SAT;
      end else begin
        m_drop = (m_drop < SAT) ? m_drop + 1 : SAT;
        m_ovf  = 1'b1;
      end
    end
  endtask

  // Compare DUT against the model, then advance the model to the state after the next rising edge.
  always @(negedge clk) begin
    if (started) begin
      bit   ev;
      bit   d;
      int   free;
      ent_t e1, e2;
      ev = (mq.size() != 0) && !hold && !clear;
      chk("count", 64'(count), 64'(mq.size()));
      chk("upd_ready", 64'(upd_ready), 64'(mq.size() <= DEPTH - 2));
      chk("wr_valid", 64'(wr_valid), 64'(ev));
      if (ev) begin
        chk("wr_pc", 64'(wr_pc), 64'(mq[0].pc));
        chk("wr_taken", 64'(wr_taken), 64'(mq[0].taken));
        chk("wr_target", 64'(wr_target), 64'(mq[0].target));
        chk("wr_type", 64'(wr_type), 64'(mq[0].typ));
      end
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("enq_cnt", 64'(enq_cnt), 64'(m_enq));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (reset) begin
        mq.delete();
        m_enq = 0; m_drop = 0; m_ovf = 1'b0;
      end else if (clear) begin
        mq.delete();
      end else begin
        d = ev && wr_ready;
        free = DEPTH - mq.size() + int'(d);
        if (d) void'(mq.pop_front());
        e1 = '{upd1_pc, upd1_taken, upd1_target, upd1_type};
        e2 = '{upd2_pc, upd2_taken, upd2_target, upd2_type};
        offer(upd1_valid, e1, free);
        offer(upd2_valid, e2, free);
      end
    end
  end

  function automatic logic [31:0] pcof(input int k);
    return 32'h1C00_0000 + 32'(k) * 32'h10;
  endfunction

  task automatic put(input bit v1, input int k1, input bit v2, input int k2);
    upd1_valid = v1; upd1_pc = pcof(k1); upd1_target = pcof(k1) ^ 32'h0000_0F00;
    upd1_taken = k1[0]; upd1_type = k1[1:0];
    upd2_valid = v2; upd2_pc = pcof(k2); upd2_target = pcof(k2) ^ 32'h0000_0F00;
    upd2_taken = k2[0]; upd2_type = k2[1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; clear = 1'b0; wr_ready = 1'b0;
    put(0, 0, 0, 0);
    @(posedge clk); #1 started = 1'b1;
    tick(); reset = 1'b0; #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_upd_ready", 64'(upd_ready), 64'd1);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_enq_cnt", 64'(enq_cnt), 64'd0);

    // Single update with one-cycle latency.
    upd1_valid = 1'b1; upd1_pc = 32'h1C00_0010; upd1_taken = 1'b1;
    upd1_target = 32'h1C00_0100; upd1_type = 2'd0; wr_ready = 1'b1;
    tick(); put(0, 0, 0, 0); #1;
    chk("t1_wr_valid", 64'(wr_valid), 64'd1);
    chk("t1_wr_pc", 64'(wr_pc), 64'h1C00_0010);
    chk("t1_wr_target", 64'(wr_target), 64'h1C00_0100);
    chk("t1_wr_taken", 64'(wr_taken), 64'd1);
    tick(); #1;
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_enq_cnt", 64'(enq_cnt), 64'd1);

    // Dual issue A..F with the predictor stalled, then one more to pass the ready threshold.
    wr_ready = 1'b0;
    put(1, 1, 1, 2); tick(); put(1, 3, 1, 4); tick(); put(1, 5, 1, 6); tick();
    put(0, 0, 0, 0); #1;
    chk("t2_count6", 64'(count), 64'd6);
    chk("t2_ready6", 64'(upd_ready), 64'd1);
    chk("t2_head_a", 64'(wr_pc), 64'(pcof(1)));
    put(1, 7, 0, 0); tick(); put(0, 0, 0, 0); #1;
    chk("t2_count7", 64'(count), 64'd7);
    chk("t2_ready7", 64'(upd_ready), 64'd0);

    // Count 7, drain and two arrivals in the same cycle: both fit.
    wr_ready = 1'b1; put(1, 8, 1, 9); #1;
    chk("t3_head_a", 64'(wr_pc), 64'(pcof(1)));
    tick(); put(0, 0, 0, 0); wr_ready = 1'b0; #1;
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t3_overflow", 64'(overflow), 64'd0);
    chk("t3_enq_cnt", 64'(enq_cnt), 64'd10);

    // Full and stalled: both arrivals dropped.
    put(1, 10, 1, 11); tick(); put(0, 0, 0, 0); #1;
    chk("t4_count", 64'(count), 64'd8);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_head_b", 64'(wr_pc), 64'(pcof(2)));
    wr_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk("t4_drain_order", 64'(wr_pc), 64'(pcof(k)));
      tick();
    end
    wr_ready = 1'b0; #1;
    chk("t4_empty", 64'(count), 64'd0);

    // Hold, then stall, then drain; slot 2 alone supplies the third entry.
    put(1, 12, 1, 13); tick(); put(0, 0, 1, 14); tick(); put(0, 0, 0, 0); #1;
    chk("t5_count", 64'(count), 64'd3);
    chk("t5_enq_cnt", 64'(enq_cnt), 64'd13);
    hold = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t5_hold_valid", 64'(wr_valid), 64'd0);
      tick();
      chk("t5_hold_count", 64'(count), 64'd3);
    end
    hold = 1'b0; wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_stall_valid", 64'(wr_valid), 64'd1);
      chk("t5_stall_pc", 64'(wr_pc), 64'(pcof(12)));
      tick();
    end
    wr_ready = 1'b1;
    for (int k = 12; k <= 14; k++) begin
      chk("t5_drain_order", 64'(wr_pc), 64'(pcof(k)));
      tick();
    end
    wr_ready = 1'b0; #1;
    chk("t5_empty", 64'(count), 64'd0);

    // Clear with an arrival present, refill, then reset mid-operation.
    put(1, 20, 1, 21); tick(); put(1, 22, 1, 23); tick(); put(1, 24, 0, 0); tick();
    put(0, 0, 0, 0); #1;
    chk("t6_count5", 64'(count), 64'd5);
    chk("t6_enq_cnt", 64'(enq_cnt), 64'd18);
    clear = 1'b1; put(1, 25, 0, 0); #1;
    chk("t6_clear_valid", 64'(wr_valid), 64'd0);
    tick(); clear = 1'b0; put(0, 0, 0, 0); #1;
    chk("t6_clr_count", 64'(count), 64'd0);
    chk("t6_clr_valid", 64'(wr_valid), 64'd0);
    chk("t6_clr_enq", 64'(enq_cnt), 64'd18);
    chk("t6_clr_drop", 64'(drop_cnt), 64'd2);
    chk("t6_clr_ovf", 64'(overflow), 64'd1);
    put(1, 26, 1, 27); tick(); put(1, 28, 1, 29); tick(); put(0, 0, 0, 0); #1;
    chk("t6_refill", 64'(count), 64'd4);
    chk("t6_refill_enq", 64'(enq_cnt), 64'd22);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_valid", 64'(wr_valid), 64'd0);
    chk("t6_rst_ready", 64'(upd_ready), 64'd1);
    chk("t6_rst_ovf", 64'(overflow), 64'd0);
    chk("t6_rst_enq", 64'(enq_cnt), 64'd0);
    chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bpu_update_sched.md
Name: bpu_update_sched

Overview:
- Scheduler between the two execute-stage branch-resolution ports and the branch predictor's single table-update port.
- Accepts up to two resolved-branch updates per cycle (slot 1 is older than slot 2) and buffers them in program order in an in-order queue.
- Drains one update per cycle to the predictor's BTB/PHT write interface under a valid/ready handshake.
- Provides backpressure, a hold for cache-install windows, a clear for predictor invalidation, and drop/occupancy statistics.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- upd1_valid  in  1  slot-1 (older) resolved branch present
- upd1_pc  in  32  branch PC
- upd1_taken  in  1  resolved direction
- upd1_target  in  32  resolved target
- upd1_type  in  2  branch type code
- upd2_valid / upd2_pc / upd2_taken / upd2_target / upd2_type  in  1/32/1/32/2  slot-2 (younger), same meanings as slot 1
- upd_ready  out  1  queue can accept two updates this cycle
- hold  in  1  suspend draining
- clear  in  1  discard all queued updates
- wr_valid  out  1  update presented to predictor
- wr_ready  in  1  predictor accepts update
- wr_pc / wr_taken / wr_target / wr_type  out  32/1/32/2  head entry fields
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: an update was dropped
- enq_cnt  out  CNT_W  saturating count of accepted updates
- drop_cnt  out  CNT_W  saturating count of dropped updates

Behaviour:
- Reset values: count=0, head=tail=0, wr_valid=0, upd_ready=1, overflow=0, enq_cnt=0, drop_cnt=0. Reset may be asserted mid-operation; all queued entries are lost.
- Queue: circular buffer of DEPTH entries {pc, taken, target, type}; head and tail pointers wrap modulo DEPTH.
- Occupancy: count is explicit, so full (count==DEPTH) and empty (count==0) are unambiguous.
- Output is show-ahead: wr_* equal the head entry combinationally; wr_* are don't-care when wr_valid=0.
- wr_valid = (count!=0) && !hold && !clear.
- Dequeue (deq) occurs when wr_valid && wr_ready; head advances by one.
- Latency: an update accepted at edge N is presentable on wr_* from cycle N+1 when the queue was empty. No same-cycle bypass.
- upd_ready = (count <= DEPTH-2), combinational from registered count. It does not depend on wr_ready.
- Enqueue space: space = DEPTH - count + deq. The same-cycle dequeue frees a slot.
- Enqueue order: slot 1 before slot 2.
  - If only upd2_valid is set, upd2 takes the single slot.
  - If both are valid and space==1, upd1 is written and upd2 is dropped.
  - If space==0, every valid update is dropped.
- Each dropped update sets overflow (sticky until reset) and increments drop_cnt.
- Producers must respect upd_ready; dropping is a recovery path only.
- enq_cnt adds the number of accepted updates (0, 1 or 2). Both counters saturate at all-ones.
- count_next = count + enq - deq.
- clear: takes priority over enqueue and dequeue in the same cycle.
  - count, head and tail are set to 0.
  - Updates presented in that cycle are discarded and are not counted as drops.
  - overflow and the statistics counters are unaffected.
- hold: wr_valid=0; enqueue continues normally.
- The head entry and wr_* stay stable while wr_valid && !wr_ready; the predictor may stall indefinitely.
- No reordering or merging. Two updates to the same PC are written in program order.

Test Plan:
- Single update: upd1_valid=1, pc=0x1C000010, taken=1, target=0x1C000100, wr_ready=1 → next cycle wr_valid=1 with those fields; cycle after, count=0, enq_cnt=1.
- Dual issue ordering: both slots valid each cycle for 3 cycles (pcs A,B / C,D / E,F), wr_ready=0 → count=6, upd_ready=0 at count=7+. Then wr_ready=1 → outputs A,B,C,D,E,F in order, one per cycle.
- Full-minus-one with same-cycle dequeue: count=DEPTH-1=7, wr_ready=1, both slots valid → space=2, both accepted, count stays 8, no drop.
- Overflow: count=8, wr_ready=0, both valid → both dropped, overflow=1, drop_cnt=2, count stays 8, head entry unchanged.
- Hold and stall: count=3, hold=1 for 4 cycles → wr_valid=0, count unchanged. Release hold with wr_ready=0 for 2 cycles → wr_* stable. Then wr_ready=1 → drains 3 entries over 3 cycles.
- Clear and reset mid-operation: count=5, assert clear with upd1_valid=1 → next cycle count=0, wr_valid=0, enq_cnt and drop_cnt unchanged. Refill to 4 entries, assert reset → all outputs return to reset values.
